// File: rtl/pong_score_keeper.sv
// pong_score_keeper: point/serve/game-over flow for Pong.
// Turns ball-miss edges into points, holds the ball for SERVE_DELAY cycles
// before each serve, and detects the winner.
// Build option: define SCORE_WIN_BY_TWO_EN for win-by-two scoring with
// saturation at 15 and sudden death at 15-15.
module pong_score_keeper #(
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned SERVE_DELAY = 50000000,
  parameter int unsigned TMR_W       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic [4:0] score_left,
  output logic [4:0] score_right,
  output logic       serve_hold,
  output logic       point_pulse,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SERVE     = 2'd1;
  localparam logic [1:0] PLAY      = 2'd2;
  localparam logic [1:0] GAME_OVER = 2'd3;

  localparam logic [4:0]       WIN5     = 5'(WIN_SCORE);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SERVE_DELAY - 1);

  logic [1:0]       state;
  logic [TMR_W-1:0] timer;
  logic             start_q;
  logic             miss_left_q;
  logic             miss_right_q;

  logic             start_ev;
  logic             left_pt_ev;   // miss_right edge: point to the left player
  logic             right_pt_ev;  // miss_left edge: point to the right player

  logic [4:0]       left_raw;
  logic [4:0]       right_raw;
  logic [4:0]       left_next;
  logic [4:0]       right_next;
  logic             left_wins;
  logic             right_wins;

  assign start_ev    = start & ~start_q;
  assign left_pt_ev  = miss_right & ~miss_right_q;
  assign right_pt_ev = miss_left & ~miss_left_q;

  // Next score and win decision for a point to either side.
  always_comb begin
    left_raw  = score_left + 5'd1;
    right_raw = score_right + 5'd1;
`ifdef SCORE_WIN_BY_TWO_EN
    // left_raw may reach 16 when the scorer already sat at 15; that case is
    // an outright win (either the lead is already 2 or it is 15-15).
    left_next  = (score_left == 5'd15) ? 5'd15 : left_raw;
    right_next = (score_right == 5'd15) ? 5'd15 : right_raw;
    left_wins  = (left_raw >= WIN5) &&
                 ((left_raw >= score_right + 5'd2) || (score_left == 5'd15));
    right_wins = (right_raw >= WIN5) &&
                 ((right_raw >= score_left + 5'd2) || (score_right == 5'd15));
`else
    left_next  = left_raw;
    right_next = right_raw;
    left_wins  = (left_raw == WIN5);
    right_wins = (right_raw == WIN5);
`endif
  end

  // Edge-detect registers, game FSM, serve timer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      start_q      <= 1'b1;
      miss_left_q  <= 1'b1;
      miss_right_q <= 1'b1;
      score_left   <= '0;
      score_right  <= '0;
      serve_hold   <= 1'b1;
      point_pulse  <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 2'b00;
    end else begin
      start_q      <= start;
      miss_left_q  <= miss_left;
      miss_right_q <= miss_right;
      point_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          serve_hold <= 1'b1;
          if (start_ev) begin
            score_left  <= '0;
            score_right <= '0;
            winner      <= 2'b00;
            game_over   <= 1'b0;
            timer       <= TMR_LOAD;
            state       <= SERVE;
          end
        end
        SERVE: begin
          if (timer == '0) begin
            serve_hold <= 1'b0;
            state      <= PLAY;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        PLAY: begin
          if (left_pt_ev && right_pt_ev) begin
            serve_hold <= 1'b1;
            timer      <= TMR_LOAD;
            state      <= SERVE;
          end else if (left_pt_ev) begin
            score_left  <= left_next;
            point_pulse <= 1'b1;
            serve_hold  <= 1'b1;
            if (left_wins) begin
              game_over <= 1'b1;
              winner    <= 2'b01;
              state     <= GAME_OVER;
            end else begin
              timer <= TMR_LOAD;
              state <= SERVE;
            end
          end else if (right_pt_ev) begin
            score_right <= right_next;
            point_pulse <= 1'b1;
            serve_hold  <= 1'b1;
            if (right_wins) begin
              game_over <= 1'b1;
              winner    <= 2'b10;
              state     <= GAME_OVER;
            end else begin
              timer <= TMR_LOAD;
              state <= SERVE;
            end
          end
        end
        GAME_OVER: begin
          serve_hold <= 1'b1;
          if (start_ev) begin
            score_left  <= '0;
            score_right <= '0;
            winner      <= 2'b00;
            game_over   <= 1'b0;
            timer       <= TMR_LOAD;
            state       <= SERVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper with WIN_SCORE=3, SERVE_DELAY=4.
// Inputs change just after a falling edge; outputs are sampled at falling edges.
module tb_pong_score_keeper;

  localparam int unsigned WIN = 3;
  localparam int unsigned SD  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       miss_left;
  logic       miss_right;
  logic [4:0] score_left;
  logic [4:0] score_right;
  logic       serve_hold;
  logic       point_pulse;
  logic       game_over;
  logic [1:0] winner;

  int tests = 0;
  int fails = 0;

  // Reference game state
  int m_l;
  int m_r;
  int m_win;
  bit m_over;

  always #5 clk = ~clk;

  pong_score_keeper #(
    .WIN_SCORE  (WIN),
    .SERVE_DELAY(SD),
    .TMR_W      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .score_left (score_left),
    .score_right(score_right),
    .serve_hold (serve_hold),
    .point_pulse(point_pulse),
    .game_over  (game_over),
    .winner     (winner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    tests++;
    assert (obs === 32'(exp)) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit exp_pulse, input bit exp_hold);
    chk({tag, ".score_left"},  32'(score_left),  m_l);
    chk({tag, ".score_right"}, 32'(score_right), m_r);
    chk({tag, ".point_pulse"}, 32'(point_pulse), int'(exp_pulse));
    chk({tag, ".serve_hold"},  32'(serve_hold),  int'(exp_hold));
    chk({tag, ".game_over"},   32'(game_over),   int'(m_over));
    chk({tag, ".winner"},      32'(winner),      m_win);
  endtask

  function automatic void model_clear();
    m_l = 0; m_r = 0; m_win = 0; m_over = 1'b0;
  endfunction

  // One point awarded to the left (to_left=1) or right player.
  function automatic void model_point(input bit to_left);
    int mine;
    int theirs;
    bit won;
    mine   = to_left ? m_l : m_r;
    theirs = to_left ? m_r : m_l;
`ifdef SCORE_WIN_BY_TWO_EN
    won  = ((mine + 1 >= int'(WIN)) && (mine + 1 - theirs >= 2)) ||
           (mine == 15 && theirs == 15);
    mine = (mine + 1 > 15) ? 15 : mine + 1;
`else
    mine = mine + 1;
    won  = (mine == int'(WIN));
`endif
    if (to_left) m_l = mine; else m_r = mine;
    if (won) begin
      m_over = 1'b1;
      m_win  = to_left ? 1 : 2;
    end
  endfunction

  // Start edge from IDLE or GAME_OVER, then the full serve hold.
  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    model_clear();
    chk_all("start", 1'b0, 1'b1);
    for (int c = 1; c <= int'(SD); c++) begin
      if (c == 1) start = 1'b0;
      @(negedge clk);
      chk_all("serve", 1'b0, c < int'(SD));
    end
  endtask

  // Hold a miss high for `hold` cycles during PLAY.
  task automatic point(input bit to_left, input int hold);
    int last;
    if (to_left) miss_right = 1'b1; else miss_left = 1'b1;
    @(negedge clk);
    model_point(to_left);
    chk_all("point", 1'b1, 1'b1);
    last = (hold > int'(SD)) ? hold : int'(SD);
    for (int c = 1; c <= last; c++) begin
      if (c == hold) begin miss_left = 1'b0; miss_right = 1'b0; end
      @(negedge clk);
      chk_all("after_point", 1'b0, m_over ? 1'b1 : (c < int'(SD)));
    end
  endtask

  task automatic both_miss();
    miss_left = 1'b1; miss_right = 1'b1;
    @(negedge clk);
    chk_all("both_miss", 1'b0, 1'b1);
    for (int c = 1; c <= int'(SD); c++) begin
      if (c == 1) begin miss_left = 1'b0; miss_right = 1'b0; end
      @(negedge clk);
      chk_all("reserve", 1'b0, c < int'(SD));
    end
  endtask

  task automatic ignored_miss(input bit to_left);
    if (to_left) miss_right = 1'b1; else miss_left = 1'b1;
    @(negedge clk);
    chk_all("over_miss", 1'b0, 1'b1);
    miss_left = 1'b0; miss_right = 1'b0;
    @(negedge clk);
    chk_all("over_miss_rel", 1'b0, 1'b1);
  endtask

  // Idle PLAY cycles with random start presses, which must be ignored.
  task automatic idle_play(input int n);
    for (int i = 0; i < n; i++) begin
      start = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      chk_all("play_idle", 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; miss_left = 1'b1; miss_right = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk_all("in_reset", 1'b0, 1'b1);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_all("reset_miss_held", 1'b0, 1'b1);
    end
    miss_left = 1'b0;
    @(negedge clk);
    chk_all("idle", 1'b0, 1'b1);

    // First game: single point from a long miss, a re-serve, right wins.
    start_game();
    point(1'b1, 10);
    chk("plan_score_left_1", 32'(score_left), 1);
    both_miss();
    idle_play(3);
    while (!m_over && m_r < 20) point(1'b0, int'($urandom_range(1, 6)));
    chk("plan_score_right_3", 32'(score_right), 3);
    chk("plan_winner_right", 32'(winner), 2);
    ignored_miss(1'b0);
    ignored_miss(1'b1);
    start_game();
    chk("plan_restart_winner", 32'(winner), 0);
    chk("plan_restart_score_r", 32'(score_right), 0);

    // Reset during a serve countdown.
    miss_right = 1'b1;
    @(negedge clk);
    model_point(1'b1);
    chk_all("rst_point", 1'b1, 1'b1);
    miss_right = 1'b0;
    @(negedge clk);
    chk_all("rst_serving", 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    model_clear();
    chk_all("rst_mid_serve", 1'b0, 1'b1);
    reset = 1'b0;
    repeat (SD + 2) begin
      @(negedge clk);
      chk_all("rst_stays_idle", 1'b0, 1'b1);
    end

`ifdef SCORE_WIN_BY_TWO_EN
    start_game();
    for (int i = 0; i < 3; i++) begin
      point(1'b1, 2);
      point(1'b0, 2);
    end
    point(1'b1, 2);
    chk("w2_4_3_score", 32'(score_left), 4);
    chk("w2_4_3_no_over", 32'(game_over), 0);
    point(1'b1, 2);
    chk("w2_left_wins", 32'(winner), 1);
    start_game();
    for (int i = 0; i < 15; i++) begin
      point(1'b0, 1);
      point(1'b1, 1);
    end
    chk("w2_15_15_no_over", 32'(game_over), 0);
    point(1'b0, 1);
    chk("w2_sudden_winner", 32'(winner), 2);
    chk("w2_sudden_score", 32'(score_right), 15);
`endif

    // Random games against the reference model.
    for (int g = 0; g < 6; g++) begin
      start_game();
      for (int k = 0; k < 100 && !m_over; k++) begin
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) both_miss();
        else point(r[0], int'($urandom_range(1, 10)));
        if (!m_over && $urandom_range(0, 1) == 1) idle_play(int'($urandom_range(1, 4)));
      end
      chk("rand_game_over", 32'(game_over), 1);
      ignored_miss(1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
